// File: rtl/alu_32.sv
`default_nettype none
// ============================================================================
//  Module      : alu_32
//  Description : 32-bit ALU for the RV64 word-sized ("W") operations. Works
//                on the low 32 bits of both operands, sign-extends the 32-bit
//                outcome to 64 bits and registers it (one cycle of latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_32 (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  alu_funct,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [63:0] result
);

    // Function-code encoding; codes 4'b1010..4'b1111 are reserved and yield 0.
    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b0001;
    localparam logic [3:0] FN_SLL  = 4'b0010;
    localparam logic [3:0] FN_SLT  = 4'b0011;
    localparam logic [3:0] FN_SLTU = 4'b0100;
    localparam logic [3:0] FN_XOR  = 4'b0101;
    localparam logic [3:0] FN_SRL  = 4'b0110;
    localparam logic [3:0] FN_SRA  = 4'b0111;
    localparam logic [3:0] FN_OR   = 4'b1000;
    localparam logic [3:0] FN_AND  = 4'b1001;

    logic [4:0]  w_shamt;
    logic [31:0] w_r32;
    logic [63:0] result_d;
    logic [63:0] result_q;

    // Only the low five bits of operand_b matter for word shifts.
    assign w_shamt = operand_b[4:0];

    // Select the 32-bit outcome of the requested operation.
    always_comb begin
        w_r32 = 32'h0;
        unique case (alu_funct)
            FN_ADD:  w_r32 = operand_a + operand_b;
            FN_SUB:  w_r32 = operand_a - operand_b;
            FN_SLL:  w_r32 = operand_a << w_shamt;
            FN_SLT:  w_r32 = {31'h0, $signed(operand_a) < $signed(operand_b)};
            FN_SLTU: w_r32 = {31'h0, operand_a < operand_b};
            FN_XOR:  w_r32 = operand_a ^ operand_b;
            FN_SRL:  w_r32 = operand_a >> w_shamt;
            FN_SRA:  w_r32 = $unsigned($signed(operand_a) >>> w_shamt);
            FN_OR:   w_r32 = operand_a | operand_b;
            FN_AND:  w_r32 = operand_a & operand_b;
            default: w_r32 = 32'h0;
        endcase
    end

    // Every word result is sign-extended, including the 0/1 of the compares.
    assign result_d = {{32{w_r32[31]}}, w_r32};

    // Output register; reset has priority over the computed value.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= 64'h0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_32
//  Description : Self-checking bench for alu_32: directed corner cases, a
//                back-to-back stream with a mid-stream reset, and random ops
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_32;

    logic        clock;
    logic        reset;
    logic [3:0]  alu_funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [63:0] result;

    int n_compared;
    int n_mismatched;

    alu_32 dut (
        .clock     (clock),
        .reset     (reset),
        .alu_funct (alu_funct),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expectation.
    task automatic check_result(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the 32-bit word, then sign-extend.
    function automatic logic [63:0] ref_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, r;
        int     sa, sb, sh;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = int'(a);
        sb = int'(b);
        sh = int'(b % 32);
        case (f)
            4'd0:    r = (ua + ub) % 64'd4294967296;
            4'd1:    r = (ua - ub + 64'd4294967296) % 64'd4294967296;
            4'd2:    r = (ua * (longint'(1) << sh)) % 64'd4294967296;
            4'd3:    r = (sa < sb) ? 1 : 0;
            4'd4:    r = (ua < ub) ? 1 : 0;
            4'd5:    r = longint'({32'h0, a ^ b});
            4'd6:    r = ua / (longint'(1) << sh);
            4'd7:    r = longint'(sa >>> sh);
            4'd8:    r = longint'({32'h0, a | b});
            4'd9:    r = longint'({32'h0, a & b});
            default: r = 0;
        endcase
        return 64'(longint'(int'(r[31:0])));
    endfunction

    // Apply one operation before the edge and check it just after the edge.
    task automatic do_op(input string tag, input logic rst_v, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        @(negedge clock);
        reset     = rst_v;
        alu_funct = f;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        check_result(tag, result, exp);
    endtask

    initial begin
        logic [3:0]  f;
        logic [31:0] a, b;
        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b1;
        alu_funct = 4'd0;
        operand_a = 32'h1234_5678;
        operand_b = 32'h9ABC_DEF0;

        // Reset held for two edges with live inputs.
        do_op("reset_edge1", 1'b1, 4'd0, 32'h7FFF_FFFF, 32'h1, 64'h0);
        do_op("reset_edge2", 1'b1, 4'd5, 32'hFFFF_FFFF, 32'h0, 64'h0);
        do_op("first_after_reset", 1'b0, 4'd0, 32'd5, 32'd3, 64'h8);

        // Directed corner cases.
        do_op("add_wrap",   1'b0, 4'd0, 32'h7FFF_FFFF, 32'h1, 64'hFFFF_FFFF_8000_0000);
        do_op("add_small",  1'b0, 4'd0, 32'd5, 32'd3, 64'h8);
        do_op("sub_borrow", 1'b0, 4'd1, 32'h0, 32'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op("slt_neg",    1'b0, 4'd3, 32'hFFFF_FFFF, 32'h1, 64'h1);
        do_op("sltu_neg",   1'b0, 4'd4, 32'hFFFF_FFFF, 32'h1, 64'h0);
        do_op("sll_mask",   1'b0, 4'd2, 32'h1, 32'h0000_003F, 64'hFFFF_FFFF_8000_0000);
        do_op("srl_31",     1'b0, 4'd6, 32'h8000_0000, 32'd31, 64'h1);
        do_op("sra_4",      1'b0, 4'd7, 32'h8000_0000, 32'd4, 64'hFFFF_FFFF_F800_0000);
        do_op("sll_zero",   1'b0, 4'd2, 32'h8765_4321, 32'hFFFF_FFE0, 64'hFFFF_FFFF_8765_4321);
        do_op("sra_zero",   1'b0, 4'd7, 32'h1234_5678, 32'h20, 64'h0000_0000_1234_5678);
        do_op("xor",        1'b0, 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'hFFFF_FFFF_FF00_FF00);
        do_op("or",         1'b0, 4'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'hFFFF_FFFF_FFF0_FFF0);
        do_op("and",        1'b0, 4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0);
        do_op("reserved_f", 1'b0, 4'd15, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0);
        do_op("reserved_a", 1'b0, 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);

        // Back-to-back stream with a reset in the middle.
        for (int i = 0; i < 8; i++) begin
            f = 4'($urandom_range(0, 9));
            a = $urandom();
            b = $urandom();
            if (i == 4) begin
                do_op("b2b_reset", 1'b1, f, a, b, 64'h0);
            end else begin
                do_op($sformatf("b2b_%0d", i), 1'b0, f, a, b, ref_model(f, a, b));
            end
        end

        // Random operations across all function codes.
        for (int i = 0; i < 400; i++) begin
            f = 4'($urandom_range(0, 15));
            a = $urandom();
            b = $urandom();
            if (i % 8 == 0) a = 32'h8000_0000 | a;
            if (i % 16 == 1) b = a;
            do_op($sformatf("rand_f%0d", f), 1'b0, f, a, b, ref_model(f, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
